// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, transaction owner encoding, default bus
// widths and a helper that maps an FSM state to the requester it serves.
package imem_dmem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_WAIT = 2'd1,
    ARB_DS_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DS   = 2'd2
  } arb_owner_e;

  // At most one transaction is ever outstanding, so the wait state alone
  // identifies who owns the response in flight.
  function automatic arb_owner_e owner_of(input arb_state_e s);
    case (s)
      ARB_IF_WAIT: return OWN_IF;
      ARB_DS_WAIT: return OWN_DS;
      default:     return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_req_mux.sv
// Picks the winning requester and muxes its fields onto the memory request.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller qualifies the selection with mem_ready.
//
// Ports: en (arbiter idle and out of reset), prefer_if (anti-starvation
// override), fetch/data request fields in, sel_if/sel_ds and mem_* fields out.
module arb_req_mux
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                en,
  input  logic                prefer_if,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                ds_req,
  input  logic                ds_we,
  input  logic [ADDR_W-1:0]   ds_addr,
  input  logic [DATA_W-1:0]   ds_wdata,
  input  logic [DATA_W/8-1:0] ds_wstrb,
  output logic                sel_if,
  output logic                sel_ds,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb
);

  always_comb begin
    sel_if    = 1'b0;
    sel_ds    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (en) begin
      // Data normally wins; prefer_if only matters when fetch is asking too.
      if (ds_req && !(prefer_if && if_req)) begin
        sel_ds = 1'b1;
      end else if (if_req) begin
        sel_if = 1'b1;
      end
      mem_req = sel_if | sel_ds;
      if (sel_ds) begin
        mem_we    = ds_we;
        mem_addr  = ds_addr;
        mem_wdata = ds_wdata;
        mem_wstrb = ds_wstrb;
      end else if (sel_if) begin
        // Fetches are always reads with no byte lanes enabled.
        mem_addr  = if_addr;
      end
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported memory between fetch and load/store, one
// transaction in flight. Latency: request and grant are combinational in
// IDLE, response is routed combinationally; one idle bubble after each
// response. Backpressure: mem_ready low holds mem_req and withholds gnt;
// requesters hold req until gnt.
//
// Ports: clk, rst_n; fetch port if_*; data port ds_*; memory port mem_*.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX back-to-back
// data grants with fetch waiting, fetch wins the next grant.
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                if_flush,
  input  logic                ds_req,
  input  logic                ds_we,
  input  logic [ADDR_W-1:0]   ds_addr,
  input  logic [DATA_W-1:0]   ds_wdata,
  input  logic [DATA_W/8-1:0] ds_wstrb,
  output logic                ds_gnt,
  output logic                ds_rvalid,
  output logic [DATA_W-1:0]   ds_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e state;
  arb_owner_e owner;
  logic       drop_q;
  logic       idle;
  logic       sel_if;
  logic       sel_ds;
  logic       prefer_if;

  // Gating with rst_n keeps every output low while reset is asserted, even
  // if requesters are already driving req.
  assign idle  = rst_n && (state == ARB_IDLE);
  assign owner = owner_of(state);

  arb_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_mux (
    .en        (idle),
    .prefer_if (prefer_if),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .ds_req    (ds_req),
    .ds_we     (ds_we),
    .ds_addr   (ds_addr),
    .ds_wdata  (ds_wdata),
    .ds_wstrb  (ds_wstrb),
    .sel_if    (sel_if),
    .sel_ds    (sel_ds),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  assign if_gnt = sel_if && mem_ready;
  assign ds_gnt = sel_ds && mem_ready;

  // A flush arriving together with the fetch response kills it as well as
  // one remembered from earlier in the wait.
  assign if_rvalid = rst_n && (owner == OWN_IF) && mem_rvalid && !drop_q && !if_flush;
  assign ds_rvalid = rst_n && (owner == OWN_DS) && mem_rvalid;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ds_rdata  = ds_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      drop_q <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          // mem_rvalid here is a stray and is deliberately ignored.
          if (if_gnt) begin
            state  <= ARB_IF_WAIT;
            drop_q <= if_flush;
          end else if (ds_gnt) begin
            state  <= ARB_DS_WAIT;
          end
        end
        ARB_IF_WAIT: begin
          if (mem_rvalid) begin
            state  <= ARB_IDLE;
            drop_q <= 1'b0;
          end else if (if_flush) begin
            drop_q <= 1'b1;
          end
        end
        ARB_DS_WAIT: begin
          if (mem_rvalid) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          state  <= ARB_IDLE;
          drop_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign prefer_if = (starve_cnt == CNT_W'(STARVE_MAX));

  // Counts data grants taken while fetch was asking; saturates so the
  // override stays armed until fetch actually gets through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if ((state == ARB_IDLE) && !if_req) begin
      starve_cnt <= '0;
    end else if (ds_gnt && if_req && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  // Strict data-over-fetch priority; STARVE_MAX is only meaningful with the
  // guard built in, the term below is constant zero.
  assign prefer_if = 1'b0 & (STARVE_MAX != 0);
`endif

endmodule
